// File: rtl/wash_phase_timer_if.sv
// Bundle between the wash controller and its phase/level timer.
// Controller side drives valves, motor and sensor; timer side returns levels and timeouts.
interface wash_phase_timer_if #(
    parameter int LW = 8
);
    logic [LW-1:0] level_raw;
    logic          motor_on;
    logic          soap_wash;
    logic          water_wash;
    logic          fill_value_on;
    logic          drain_value_on;
    logic          filled;
    logic          drained;
    logic          cycle_timeout;
    logic          spin_timeout;
    logic          fault;
    logic [1:0]    fault_code;

    modport master (
        output level_raw, motor_on, soap_wash, water_wash,
        output fill_value_on, drain_value_on,
        input  filled, drained, cycle_timeout, spin_timeout,
        input  fault, fault_code
    );

    modport slave (
        input  level_raw, motor_on, soap_wash, water_wash,
        input  fill_value_on, drain_value_on,
        output filled, drained, cycle_timeout, spin_timeout,
        output fault, fault_code
    );
endinterface

// File: rtl/wash_phase_timer.sv
// Level debounce, phase timing and fill/drain watchdogs feeding
// the washing-machine controller; all outputs registered.
module wash_phase_timer #(
    parameter int LW          = 8,
    parameter int FULL_LEVEL  = 200,
    parameter int EMPTY_LEVEL = 10,
    parameter int HYST        = 8,
    parameter int DEB_CYC     = 3,
    parameter int WASH_CYC    = 20,
    parameter int RINSE_CYC   = 12,
    parameter int SPIN_CYC    = 8,
    parameter int FILL_MAX    = 100,
    parameter int DRAIN_MAX   = 60
) (
    input logic              clk,
    input logic              reset,
    wash_phase_timer_if.slave bus
);
    localparam int LMAX    = (1 << LW) - 1;
    localparam int FULL_S  = (FULL_LEVEL > LMAX) ? LMAX : FULL_LEVEL;
    localparam int EMPTY_S = (EMPTY_LEVEL > LMAX) ? LMAX : EMPTY_LEVEL;
    localparam int FLO_I   = (FULL_S > HYST) ? FULL_S - HYST : 0;
    localparam int EHI_I   = (EMPTY_S + HYST > LMAX) ? LMAX : EMPTY_S + HYST;

    localparam logic [LW:0] FULL_HI  = FULL_S[LW:0];
    localparam logic [LW:0] FULL_LO  = FLO_I[LW:0];
    localparam logic [LW:0] EMPTY_LO = EMPTY_S[LW:0];
    localparam logic [LW:0] EMPTY_HI = EHI_I[LW:0];

    localparam int DW = $clog2(DEB_CYC) + 1;
    localparam logic [DW-1:0] DEB_N = DW'(DEB_CYC);

    localparam int WMAX = (FILL_MAX > DRAIN_MAX) ? FILL_MAX : DRAIN_MAX;
    localparam int WW   = $clog2(WMAX) + 1;
    localparam logic [WW-1:0] FILL_N  = WW'(FILL_MAX);
    localparam logic [WW-1:0] DRAIN_N = WW'(DRAIN_MAX);

    localparam int PM0  = (WASH_CYC > RINSE_CYC) ? WASH_CYC : RINSE_CYC;
    localparam int PMAX = (PM0 > SPIN_CYC) ? PM0 : SPIN_CYC;
    localparam int PW   = $clog2(PMAX) + 1;
    localparam logic [PW-1:0] WASH_LD  = PW'(WASH_CYC - 2);
    localparam logic [PW-1:0] RINSE_LD = PW'(RINSE_CYC - 2);
    localparam logic [PW-1:0] SPIN_LD  = PW'(SPIN_CYC - 2);

    typedef enum logic [2:0] {
        IDLE, WASH, RINSE, SPIN, EXPIRED
    } state_t;

    state_t        state_q, state_d;
    state_t        ph_q, ph_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] full_cnt, full_nx, empty_cnt, empty_nx;
    logic [WW-1:0] fill_cnt, fill_nx, drain_cnt, drain_nx;
    logic          filled_d, drained_d, fault_d;
    logic          cyc_d, spn_d;
    logic [1:0]    code_d;

    logic [LW:0] lvl;
    logic        at_full, below_full, at_empty, above_empty;
    logic        wash_c, rinse_c, spin_c, run_c;
    logic        fill_q, drain_q, fill_hit, drain_hit;
    state_t      sel;

    assign lvl         = {1'b0, bus.level_raw};
    assign at_full     = lvl >= FULL_HI;
    assign below_full  = lvl < FULL_LO;
    assign at_empty    = lvl <= EMPTY_LO;
    assign above_empty = lvl > EMPTY_HI;

    assign wash_c  = bus.motor_on & bus.soap_wash;
    assign rinse_c = bus.motor_on & bus.water_wash & ~bus.soap_wash;
    assign spin_c  = bus.motor_on & bus.drain_value_on
                   & ~bus.soap_wash & ~bus.water_wash;

    // EXPIRED keeps checking the condition of the phase that timed out
    assign sel   = (state_q == EXPIRED) ? ph_q : state_q;
    assign run_c = ((sel == WASH) & wash_c)
                 | ((sel == RINSE) & rinse_c)
                 | ((sel == SPIN) & spin_c);

    assign fill_q  = bus.fill_value_on & ~bus.filled;
    assign drain_q = bus.drain_value_on & ~bus.drained;

    always_comb begin
        full_nx = '0;
        if (at_full)
            full_nx = (full_cnt == DEB_N) ? DEB_N : full_cnt + DW'(1);
        empty_nx = '0;
        if (at_empty)
            empty_nx = (empty_cnt == DEB_N) ? DEB_N : empty_cnt + DW'(1);

        filled_d = bus.filled;
        if (at_full && full_nx == DEB_N)
            filled_d = 1'b1;
        else if (below_full)
            filled_d = 1'b0;

        drained_d = bus.drained;
        if (at_empty && empty_nx == DEB_N)
            drained_d = 1'b1;
        else if (above_empty)
            drained_d = 1'b0;
    end

    always_comb begin
        fill_nx = '0;
        if (fill_q)
            fill_nx = (fill_cnt == FILL_N) ? FILL_N : fill_cnt + WW'(1);
        drain_nx = '0;
        if (drain_q)
            drain_nx = (drain_cnt == DRAIN_N) ? DRAIN_N : drain_cnt + WW'(1);
        fill_hit  = fill_nx == FILL_N;
        drain_hit = drain_nx == DRAIN_N;

        fault_d = bus.fault;
        code_d  = bus.fault_code;
        // first fault latches; fill wins a same-edge tie
        if (!bus.fault && fill_hit) begin
            fault_d = 1'b1;
            code_d  = 2'b01;
        end else if (!bus.fault && drain_hit) begin
            fault_d = 1'b1;
            code_d  = 2'b10;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    wash_c: begin
                        state_d = WASH;
                        ph_d    = WASH;
                        cnt_d   = WASH_LD;
                    end
                    rinse_c: begin
                        state_d = RINSE;
                        ph_d    = RINSE;
                        cnt_d   = RINSE_LD;
                    end
                    spin_c: begin
                        state_d = SPIN;
                        ph_d    = SPIN;
                        cnt_d   = SPIN_LD;
                    end
                    default: ;
                endcase
            end
            WASH, RINSE, SPIN: begin
                if (!run_c)
                    state_d = IDLE;
                else if (cnt_q == '0)
                    state_d = EXPIRED;
                else
                    cnt_d = cnt_q - PW'(1);
            end
            EXPIRED: begin
                if (!run_c)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        cyc_d = (state_d == EXPIRED) && (ph_d != SPIN);
        spn_d = (state_d == EXPIRED) && (ph_d == SPIN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q           <= IDLE;
            ph_q              <= IDLE;
            cnt_q             <= '0;
            full_cnt          <= '0;
            empty_cnt         <= '0;
            fill_cnt          <= '0;
            drain_cnt         <= '0;
            bus.filled        <= 1'b0;
            bus.drained       <= 1'b0;
            bus.cycle_timeout <= 1'b0;
            bus.spin_timeout  <= 1'b0;
            bus.fault         <= 1'b0;
            bus.fault_code    <= 2'b00;
        end else begin
            state_q           <= state_d;
            ph_q              <= ph_d;
            cnt_q             <= cnt_d;
            full_cnt          <= full_nx;
            empty_cnt         <= empty_nx;
            fill_cnt          <= fill_nx;
            drain_cnt         <= drain_nx;
            bus.filled        <= filled_d;
            bus.drained       <= drained_d;
            bus.cycle_timeout <= cyc_d;
            bus.spin_timeout  <= spn_d;
            bus.fault         <= fault_d;
            bus.fault_code    <= code_d;
        end
    end
endmodule

// File: doc/wash_phase_timer.md
Name: wash_phase_timer

Overview:
- Sensor-conditioning and timing stage directly upstream of automatic_washing_machine.
- Generates that controller's filled, drained, cycle_timeout and spin_timeout inputs from a raw water-level sensor and from the controller's own motor, valve and phase outputs, which are fed back.
- Also flags fill and drain watchdog faults for the top level.

Parameters:
- LW, 8, level sensor width
- FULL_LEVEL, 200, raw level at or above which the tank counts as full
- EMPTY_LEVEL, 10, raw level at or below which the tank counts as empty
- HYST, 8, release hysteresis for filled and drained, in level units
- DEB_CYC, 3, consecutive qualifying cycles needed to set filled or drained (at least 1)
- WASH_CYC, 20, soap-wash phase length in cycles (at least 2)
- RINSE_CYC, 12, water-wash (rinse) phase length in cycles (at least 2)
- SPIN_CYC, 8, spin phase length in cycles (at least 2)
- FILL_MAX, 100, fill watchdog limit in cycles
- DRAIN_MAX, 60, drain watchdog limit in cycles

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low; reset=0 at a rising edge resets the block
- level_raw  in  LW  unsigned water-level sample
- motor_on  in  1  from the controller
- soap_wash  in  1  from the controller
- water_wash  in  1  from the controller
- fill_value_on  in  1  from the controller
- drain_value_on  in  1  from the controller
- filled  out  1  debounced tank-full level
- drained  out  1  debounced tank-empty level
- cycle_timeout  out  1  wash or rinse phase expired
- spin_timeout  out  1  spin phase expired
- fault  out  1  sticky watchdog fault
- fault_code  out  2  01 = fill timeout, 10 = drain timeout, 00 = no fault

Behaviour:
- Reset and registering
  - While reset=0, every output is 0 and all counters clear.
  - drained is 0 out of reset even if the tank is empty; it sets DEB_CYC cycles later.
  - All outputs are registered.
- filled
  - Sets on the DEB_CYC-th consecutive edge with level_raw >= FULL_LEVEL.
  - Clears on the first edge with level_raw < FULL_LEVEL-HYST.
  - Between the two thresholds it holds its value, and the debounce count resets.
- drained
  - Sets on the DEB_CYC-th consecutive edge with level_raw <= EMPTY_LEVEL.
  - Clears on the first edge with level_raw > EMPTY_LEVEL+HYST.
  - Level sensing is independent of valve state.
- Threshold arithmetic: compute with LW+1 bits, saturated at 0 and 2^LW-1.
- Phase FSM states: IDLE, WASH, RINSE, SPIN, EXPIRED.
  - WASH condition C = motor_on & soap_wash; this has priority when soap_wash and water_wash are both high.
  - RINSE condition C = motor_on & water_wash & ~soap_wash.
  - SPIN condition C = motor_on & drain_value_on & ~soap_wash & ~water_wash.
  - IDLE: on an edge where a condition is true, enter that state and load counter = N-2, where N is the phase length.
  - Phase states: while C holds, decrement each edge. At an edge with counter==0 and C still true, go to EXPIRED and set the phase's timeout output.
  - Net latency: the timeout is high after the N-th consecutive edge at which C was sampled true.
  - If C drops before expiry, return to IDLE with no timeout. There is no pause or resume; re-entry restarts the full N.
  - A switch between wash and rinse mid-phase counts as a drop and goes through IDLE.
  - EXPIRED: hold the timeout high while C holds. At the edge C is sampled false, go to IDLE and clear the timeout.
  - cycle_timeout and spin_timeout are never high together.
- Fill watchdog
  - Counts consecutive edges with fill_value_on=1 and filled=0; the count clears otherwise.
  - At count FILL_MAX, fault=1 and fault_code=01.
- Drain watchdog
  - Counts consecutive edges with drain_value_on=1 and drained=0.
  - At count DRAIN_MAX, fault=1 and fault_code=10.
- Fault behaviour
  - The first fault wins and latches until reset; a later watchdog does not change fault_code.
  - If both watchdogs reach their limit on the same edge, fault_code=01.
- Reset mid-phase or mid-debounce aborts immediately with outputs 0. No state survives.
- Counter widths: $clog2 of the largest relevant parameter, plus 1. Counters never wrap; they saturate at their limit.

Test Plan:
- Debounce set and release: hold level_raw=200 for 3 edges -> filled=1 after the 3rd edge, not after the 2nd. Drop to 195 -> filled stays 1. Drop to 191 -> filled=0 after 1 edge. A 199/200 toggle never sets filled.
- Wash timing: motor_on=1 and soap_wash=1 held -> cycle_timeout=1 after exactly edge 20 and stays high. Drop soap_wash -> cycle_timeout=0 one edge later and FSM returns to IDLE.
- Abort and restart: soap_wash high 10 edges, low 1 edge, high again -> no timeout until 20 edges after re-entry.
- Priority and spin: soap_wash and water_wash both high -> 20-cycle wash timing, not 12. Then motor_on=1 and drain_value_on=1 alone -> spin_timeout=1 after 8 edges, with cycle_timeout=0 throughout.
- Watchdogs: fill_value_on=1 with level_raw=0 -> fault=1 and fault_code=01 at edge 100. Raising level afterwards does not clear the fault. Drain case -> fault_code=10 at edge 60. Both on the same edge -> fault_code=01.
- Reset: reset=0 asserted mid-spin at edge 5 -> all outputs 0 on that edge. Release with level_raw=0 -> drained=1 3 edges later.
